// File: rtl/rv32im_wb_timer_pkg.sv
// Shared constants, state type and byte-lane helper for the Wishbone machine timer.
// Register offsets are word offsets decoded from adr_i[2:0].
package rv32im_wb_timer_pkg;

   localparam logic [2:0] OFF_MTIME_LO = 3'd0;
   localparam logic [2:0] OFF_MTIME_HI = 3'd1;
   localparam logic [2:0] OFF_CMP_LO   = 3'd2;
   localparam logic [2:0] OFF_CMP_HI   = 3'd3;
   localparam logic [2:0] OFF_CTRL     = 3'd4;
   localparam logic [2:0] OFF_PRESCALE = 3'd5;

   localparam int CTRL_EN_BIT  = 0;
   localparam int CTRL_IRQ_BIT = 1;

   localparam logic [63:0] MTIMECMP_RESET = 64'hFFFF_FFFF_FFFF_FFFF;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_RESP = 2'd2
   } wb_state_e;

   function automatic logic [31:0] byte_merge(input logic [31:0] old_val,
                                              input logic [31:0] new_val,
                                              input logic [3:0]  sel);
      logic [31:0] merged;
      merged = old_val;
      for (int k = 0; k < 4; k++) begin
         if (sel[k]) merged[8*k +: 8] = new_val[8*k +: 8];
      end
      return merged;
   endfunction

   function automatic logic is_err_offset(input logic [2:0] off);
      return off > OFF_PRESCALE;
   endfunction

endpackage

// File: rtl/rv32im_wb_timer_core.sv
// Timer datapath: prescaler, 64-bit mtime/mtimecmp, control bits and registered interrupt.
// A bus write to mtime wins over a coincident prescaler tick, which is then lost.
module rv32im_timer_core
   import rv32im_wb_timer_pkg::*;
(
   input  logic        clk_i,
   input  logic        reset_ni,
   input  logic        wr_en,
   input  logic [2:0]  wr_off,
   input  logic [3:0]  wr_sel,
   input  logic [31:0] wr_dat,
   output logic [63:0] mtime,
   output logic [63:0] mtimecmp,
   output logic [31:0] prescale,
   output logic        timer_en,
   output logic        irq_en,
   output logic        interrupt_o
);

   logic [31:0] presc_cnt;
   logic [31:0] presc_cnt_d;
   logic [31:0] prescale_d;
   logic [63:0] mtime_d;
   logic [63:0] mtimecmp_d;
   logic        timer_en_d;
   logic        irq_en_d;
   logic        tick;
   logic        time_wr;

   always_comb begin
      tick        = timer_en && (presc_cnt == prescale);
      time_wr     = wr_en && (wr_sel != 4'b0000) &&
                    ((wr_off == OFF_MTIME_LO) || (wr_off == OFF_MTIME_HI));
      mtime_d     = (tick && !time_wr) ? mtime + 64'd1 : mtime;
      mtimecmp_d  = mtimecmp;
      prescale_d  = prescale;
      timer_en_d  = timer_en;
      irq_en_d    = irq_en;
      presc_cnt_d = presc_cnt;
      if (timer_en) presc_cnt_d = tick ? 32'd0 : presc_cnt + 32'd1;
      if (wr_en) begin
         case (wr_off)
            OFF_MTIME_LO: mtime_d[31:0]     = byte_merge(mtime_d[31:0], wr_dat, wr_sel);
            OFF_MTIME_HI: mtime_d[63:32]    = byte_merge(mtime_d[63:32], wr_dat, wr_sel);
            OFF_CMP_LO:   mtimecmp_d[31:0]  = byte_merge(mtimecmp[31:0], wr_dat, wr_sel);
            OFF_CMP_HI:   mtimecmp_d[63:32] = byte_merge(mtimecmp[63:32], wr_dat, wr_sel);
            OFF_CTRL: begin
               if (wr_sel[0]) begin
                  timer_en_d = wr_dat[CTRL_EN_BIT];
                  irq_en_d   = wr_dat[CTRL_IRQ_BIT];
               end
            end
            OFF_PRESCALE: begin
               prescale_d  = byte_merge(prescale, wr_dat, wr_sel);
               presc_cnt_d = 32'd0;
            end
            default: ;
         endcase
      end
   end

   // Interrupt compares the current register state, so it trails mtime/mtimecmp by a cycle.
   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         mtime       <= 64'd0;
         mtimecmp    <= MTIMECMP_RESET;
         prescale    <= 32'd0;
         presc_cnt   <= 32'd0;
         timer_en    <= 1'b0;
         irq_en      <= 1'b0;
         interrupt_o <= 1'b0;
      end else begin
         mtime       <= mtime_d;
         mtimecmp    <= mtimecmp_d;
         prescale    <= prescale_d;
         presc_cnt   <= presc_cnt_d;
         timer_en    <= timer_en_d;
         irq_en      <= irq_en_d;
         interrupt_o <= irq_en && (mtime >= mtimecmp);
      end
   end

endmodule

// File: rtl/rv32im_wb_timer.sv
// Wishbone classic single-beat responder in front of the machine timer core.
// Holds the bus FSM, request capture, mtime high-word shadow and the read mux.
module rv32im_wb_timer
   import rv32im_wb_timer_pkg::*;
#(
   parameter int XLEN        = 32,
   parameter int WAIT_STATES = 0
)
(
   input  logic            clk_i,
   input  logic            reset_ni,
   input  logic [XLEN-1:0] slave_dat_i,
   output logic [XLEN-1:0] slave_dat_o,
   input  logic [XLEN-3:0] adr_i,
   input  logic            cyc_i,
   input  logic            stb_i,
   input  logic            we_i,
   input  logic [3:0]      sel_i,
   output logic            ack_o,
   output logic            err_o,
   output logic            interrupt_o
);

   wb_state_e   state_q;
   wb_state_e   state_d;
   logic [3:0]  wait_cnt_q;
   logic [3:0]  wait_cnt_d;
   logic [2:0]  adr_q;
   logic        we_q;
   logic [3:0]  sel_q;
   logic [31:0] dat_q;
   logic [2:0]  cur_adr;
   logic        cur_we;
   logic [3:0]  cur_sel;
   logic [31:0] cur_dat;
   logic        cur_err;
   logic        commit;
   logic [31:0] shadow;
   logic [31:0] rd_data;
   logic [63:0] mtime;
   logic [63:0] mtimecmp;
   logic [31:0] prescale;
   logic        timer_en;
   logic        irq_en;
   logic        unused_adr;

   assign unused_adr = ^adr_i[XLEN-3:3];

   always_comb begin
      state_d    = state_q;
      wait_cnt_d = wait_cnt_q;
      case (state_q)
         ST_IDLE: begin
            if (cyc_i && stb_i) begin
               if (WAIT_STATES == 0) begin
                  state_d = ST_RESP;
               end else begin
                  state_d    = ST_WAIT;
                  wait_cnt_d = 4'(WAIT_STATES);
               end
            end
         end
         ST_WAIT: begin
            if (!cyc_i)                 state_d = ST_IDLE;
            else if (wait_cnt_q == 4'd1) state_d = ST_RESP;
            else                         wait_cnt_d = wait_cnt_q - 4'd1;
         end
         ST_RESP: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // With no wait states the request commits on the edge that samples it, so use live inputs.
   always_comb begin
      if (state_q == ST_IDLE) begin
         cur_adr = adr_i[2:0];
         cur_we  = we_i;
         cur_sel = sel_i;
         cur_dat = slave_dat_i[31:0];
      end else begin
         cur_adr = adr_q;
         cur_we  = we_q;
         cur_sel = sel_q;
         cur_dat = dat_q;
      end
      commit  = (state_d == ST_RESP);
      cur_err = is_err_offset(cur_adr);
   end

   always_comb begin
      rd_data = 32'd0;
      case (cur_adr)
         OFF_MTIME_LO: rd_data = mtime[31:0];
         OFF_MTIME_HI: rd_data = shadow;
         OFF_CMP_LO:   rd_data = mtimecmp[31:0];
         OFF_CMP_HI:   rd_data = mtimecmp[63:32];
         OFF_CTRL:     rd_data = {30'd0, irq_en, timer_en};
         OFF_PRESCALE: rd_data = prescale;
         default:      rd_data = 32'd0;
      endcase
   end

   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         state_q     <= ST_IDLE;
         wait_cnt_q  <= 4'd0;
         adr_q       <= 3'd0;
         we_q        <= 1'b0;
         sel_q       <= 4'd0;
         dat_q       <= 32'd0;
         ack_o       <= 1'b0;
         err_o       <= 1'b0;
         slave_dat_o <= '0;
         shadow      <= 32'd0;
      end else begin
         state_q    <= state_d;
         wait_cnt_q <= wait_cnt_d;
         if (state_q == ST_IDLE && cyc_i && stb_i) begin
            adr_q <= adr_i[2:0];
            we_q  <= we_i;
            sel_q <= sel_i;
            dat_q <= slave_dat_i[31:0];
         end
         ack_o       <= commit && !cur_err;
         err_o       <= commit && cur_err;
         slave_dat_o <= (commit && !cur_we && !cur_err) ? XLEN'(rd_data) : '0;
         // Latching the live high word on a low-word read makes lo-then-hi reads coherent.
         if (commit && !cur_we && cur_adr == OFF_MTIME_LO) shadow <= mtime[63:32];
      end
   end

   rv32im_timer_core u_core (
      .clk_i       (clk_i),
      .reset_ni    (reset_ni),
      .wr_en       (commit && cur_we && !cur_err),
      .wr_off      (cur_adr),
      .wr_sel      (cur_sel),
      .wr_dat      (cur_dat),
      .mtime       (mtime),
      .mtimecmp    (mtimecmp),
      .prescale    (prescale),
      .timer_en    (timer_en),
      .irq_en      (irq_en),
      .interrupt_o (interrupt_o)
   );

endmodule
